// File: rtl/suite_pkg.sv
// Shared types and widths for the suite pattern loader.
package suite_pkg;

  localparam int WORD_W      = 16;
  localparam int WADDR_W     = 16;
  localparam int BYTE_ADDR_W = 17;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/suite_loader.sv
// Packs the HPS byte download into 16-bit pattern RAM words and holds the
// suite core in reset until the load has settled.
module suite_loader
  import suite_pkg::*;
#(
  parameter int MAX_BYTES      = 65536,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [BYTE_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]             ioctl_data,
  output logic                   ram_we,
  output logic [WADDR_W-1:0]     ram_addr,
  output logic [WORD_W-1:0]      ram_wdata,
  output logic                   core_reset,
  output logic                   load_done,
  output logic                   load_err,
  output logic [BYTE_ADDR_W-1:0] load_len
);

  localparam int RCW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [BYTE_ADDR_W:0] MAX_B    = (BYTE_ADDR_W+1)'(MAX_BYTES);
  localparam logic [RCW-1:0]       REL_LAST = RCW'(RELEASE_CYCLES - 1);

  state_e                 state, state_nxt;
  logic                   load_entry;
  logic [BYTE_ADDR_W-1:0] exp_addr, exp_cur, len_cur;
  logic [7:0]             pend_byte;
  logic                   pend_vld;
  logic [RCW-1:0]         rel_cnt;
  logic                   byte_take, addr_ok, accept, drop;

  always_comb begin
    state_nxt  = state;
    load_entry = 1'b0;
    core_reset = 1'b0;
    load_done  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        load_done = (state == ST_DONE);
        if (ioctl_download) begin
          state_nxt  = ST_LOAD;
          load_entry = 1'b1;
        end
      end
      ST_LOAD: begin
        core_reset = 1'b1;
        if (!ioctl_download) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        core_reset = 1'b1;
        if (ioctl_download) begin
          state_nxt  = ST_LOAD;
          load_entry = 1'b1;
        end else begin
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        core_reset = 1'b1;
        if (ioctl_download) begin
          state_nxt  = ST_LOAD;
          load_entry = 1'b1;
        end else if (rel_cnt == REL_LAST) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A strobe on the entry edge is judged against the freshly cleared counters.
  always_comb begin
    exp_cur   = load_entry ? '0 : exp_addr;
    len_cur   = load_entry ? '0 : load_len;
    byte_take = ioctl_wr && ((state == ST_LOAD) || load_entry);
    addr_ok   = (ioctl_addr == exp_cur) && ({1'b0, ioctl_addr} < MAX_B);
    accept    = byte_take && addr_ok;
    drop      = byte_take && !addr_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      load_err  <= 1'b0;
      load_len  <= '0;
      exp_addr  <= '0;
      pend_byte <= '0;
      pend_vld  <= 1'b0;
      rel_cnt   <= '0;
    end else begin
      state  <= state_nxt;
      ram_we <= 1'b0;

      // Odd trailing byte goes out zero-padded; exp_addr is odd here so >>1 is its word.
      if (state == ST_FLUSH && pend_vld) begin
        ram_we    <= 1'b1;
        ram_addr  <= exp_addr[BYTE_ADDR_W-1:1];
        ram_wdata <= {8'h00, pend_byte};
        pend_vld  <= 1'b0;
      end

      if (state == ST_RELEASE) rel_cnt <= rel_cnt + 1'b1;
      else                     rel_cnt <= '0;

      if (load_entry) begin
        exp_addr  <= '0;
        load_len  <= '0;
        load_err  <= 1'b0;
        pend_byte <= '0;
        pend_vld  <= 1'b0;
      end

      if (accept) begin
        exp_addr <= exp_cur + 1'b1;
        load_len <= len_cur + 1'b1;
        if (ioctl_addr[0]) begin
          ram_we    <= 1'b1;
          ram_addr  <= ioctl_addr[BYTE_ADDR_W-1:1];
          ram_wdata <= {ioctl_data, pend_byte};
          pend_vld  <= 1'b0;
        end else begin
          pend_byte <= ioctl_data;
          pend_vld  <= 1'b1;
        end
      end

      if (drop) load_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_suite_loader.sv
// Directed table-driven bench for suite_loader (small MAX_BYTES to reach the boundary).
module tb_suite_loader;

  localparam int MAXB = 4;
  localparam int REL  = 16;

  logic        clk = 1'b0;
  logic        reset, ioctl_download, ioctl_wr;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ram_we, core_reset, load_done, load_err;
  logic [15:0] ram_addr, ram_wdata;
  logic [16:0] load_len;

  int checks = 0;
  int passes = 0;
  int rid    = 0;

  typedef struct {
    int          id;
    logic        rst, dl, wr;
    logic [16:0] a;
    logic [7:0]  d;
    logic        we;
    logic [15:0] wa, wd;
    logic        cr, dn, er;
    logic [16:0] ln;
  } vec_t;

  vec_t vq[$];

  suite_loader #(.MAX_BYTES(MAXB), .RELEASE_CYCLES(REL)) dut (
    .clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .core_reset(core_reset), .load_done(load_done),
    .load_err(load_err), .load_len(load_len)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic row(input logic r, dl, wr, input logic [16:0] a, input logic [7:0] d,
                     input logic we, input logic [15:0] wa, wd,
                     input logic cr, dn, er, input logic [16:0] ln);
    vec_t v;
    rid++;
    v.id = rid; v.rst = r; v.dl = dl; v.wr = wr; v.a = a; v.d = d;
    v.we = we; v.wa = wa; v.wd = wd; v.cr = cr; v.dn = dn; v.er = er; v.ln = ln;
    vq.push_back(v);
  endtask

  task automatic run_rows();
    foreach (vq[i]) begin
      reset = vq[i].rst; ioctl_download = vq[i].dl; ioctl_wr = vq[i].wr;
      ioctl_addr = vq[i].a; ioctl_data = vq[i].d;
      step();
      chk($sformatf("r%0d ram_we", vq[i].id), 32'(ram_we), 32'(vq[i].we));
      if (vq[i].we) begin
        chk($sformatf("r%0d ram_addr", vq[i].id), 32'(ram_addr), 32'(vq[i].wa));
        chk($sformatf("r%0d ram_wdata", vq[i].id), 32'(ram_wdata), 32'(vq[i].wd));
      end
      chk($sformatf("r%0d core_reset", vq[i].id), 32'(core_reset), 32'(vq[i].cr));
      chk($sformatf("r%0d load_done", vq[i].id), 32'(load_done), 32'(vq[i].dn));
      chk($sformatf("r%0d load_err", vq[i].id), 32'(load_err), 32'(vq[i].er));
      chk($sformatf("r%0d load_len", vq[i].id), 32'(load_len), 32'(vq[i].ln));
    end
    ioctl_wr = 1'b0;
    vq.delete();
  endtask

  // Entered just after the first RELEASE sample; counts core_reset-high samples until DONE.
  task automatic wait_release(input string nm, input logic err, input logic [16:0] len);
    int n = 1;
    ioctl_download = 1'b0; ioctl_wr = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!core_reset) break;
      n++;
    end
    chk({nm, " release_cycles"}, 32'(n), 32'(REL));
    chk({nm, " load_done"}, 32'(load_done), 32'd1);
    chk({nm, " core_reset"}, 32'(core_reset), 32'd0);
    chk({nm, " load_err"}, 32'(load_err), 32'(err));
    chk({nm, " load_len"}, 32'(load_len), 32'(len));
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_data = '0;
    step(); step();
    chk("rst ram_we", 32'(ram_we), 0);
    chk("rst ram_addr", 32'(ram_addr), 0);
    chk("rst ram_wdata", 32'(ram_wdata), 0);
    chk("rst core_reset", 32'(core_reset), 0);
    chk("rst load_done", 32'(load_done), 0);
    chk("rst load_err", 32'(load_err), 0);
    chk("rst load_len", 32'(load_len), 0);

    // Four-byte load, then a byte at the capacity boundary
    row(0,1,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,0,17'd0);
    row(0,1,1,17'd0,8'h11, 0,16'h0,16'h0000, 1,0,0,17'd1);
    row(0,1,1,17'd1,8'h22, 1,16'h0,16'h2211, 1,0,0,17'd2);
    row(0,1,1,17'd2,8'h33, 0,16'h0,16'h0000, 1,0,0,17'd3);
    row(0,1,1,17'd3,8'h44, 1,16'h1,16'h4433, 1,0,0,17'd4);
    row(0,1,1,17'd4,8'h55, 0,16'h0,16'h0000, 1,0,1,17'd4);
    row(0,0,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,1,17'd4);
    row(0,0,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,1,17'd4);
    run_rows();
    wait_release("A", 1'b1, 17'd4);

    // Odd-length load: flush writes the zero-padded tail
    row(0,1,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,0,17'd0);
    row(0,1,1,17'd0,8'hAA, 0,16'h0,16'h0000, 1,0,0,17'd1);
    row(0,1,1,17'd1,8'hBB, 1,16'h0,16'hBBAA, 1,0,0,17'd2);
    row(0,1,1,17'd2,8'hCC, 0,16'h0,16'h0000, 1,0,0,17'd3);
    row(0,0,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,0,17'd3);
    row(0,0,0,17'd0,8'h00, 1,16'h1,16'h00CC, 1,0,0,17'd3);
    run_rows();
    wait_release("B", 1'b0, 17'd3);

    // Gap at addr 3, reload from RELEASE, strobe coinciding with download fall, reset in RELEASE
    row(0,1,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,0,17'd0);
    row(0,1,1,17'd0,8'h01, 0,16'h0,16'h0000, 1,0,0,17'd1);
    row(0,1,1,17'd1,8'h02, 1,16'h0,16'h0201, 1,0,0,17'd2);
    row(0,1,1,17'd3,8'h04, 0,16'h0,16'h0000, 1,0,1,17'd2);
    row(0,0,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,1,17'd2);
    row(0,0,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,1,17'd2);
    row(0,0,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,1,17'd2);
    row(0,1,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,0,17'd0);
    row(0,1,1,17'd0,8'h55, 0,16'h0,16'h0000, 1,0,0,17'd1);
    row(0,1,1,17'd1,8'h66, 1,16'h0,16'h6655, 1,0,0,17'd2);
    row(0,1,1,17'd2,8'h77, 0,16'h0,16'h0000, 1,0,0,17'd3);
    row(0,0,1,17'd3,8'h88, 1,16'h1,16'h8877, 1,0,0,17'd4);
    row(0,0,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,0,17'd4);
    for (int k = 0; k < 4; k++)
      row(0,0,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,0,17'd4);
    row(1,0,0,17'd0,8'h00, 0,16'h0,16'h0000, 0,0,0,17'd0);
    row(0,0,0,17'd0,8'h00, 0,16'h0,16'h0000, 0,0,0,17'd0);
    run_rows();
    chk("C post-reset ram_addr", 32'(ram_addr), 0);
    chk("C post-reset ram_wdata", 32'(ram_wdata), 0);

    // Download re-asserted in FLUSH with a pending byte
    row(0,1,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,0,17'd0);
    row(0,1,1,17'd0,8'h9A, 0,16'h0,16'h0000, 1,0,0,17'd1);
    row(0,0,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,0,17'd1);
    row(0,1,0,17'd0,8'h00, 1,16'h0,16'h009A, 1,0,0,17'd0);
    row(0,1,1,17'd0,8'hE1, 0,16'h0,16'h0000, 1,0,0,17'd1);
    row(0,1,1,17'd1,8'hE2, 1,16'h0,16'hE2E1, 1,0,0,17'd2);
    row(0,0,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,0,17'd2);
    row(0,0,0,17'd0,8'h00, 0,16'h0,16'h0000, 1,0,0,17'd2);
    run_rows();
    wait_release("D", 1'b0, 17'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/suite_loader.md
SUITE_LOADER -- requirements
Module: suite_loader

Interface
REQ-001 The block SHALL have parameter MAX_BYTES, default 65536, the byte capacity of the pattern RAM.
REQ-002 The block SHALL have parameter RELEASE_CYCLES, default 16, the core-reset hold after a load completes.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port ioctl_download  input  1  HPS download window active.
REQ-006 The block SHALL have port ioctl_wr  input  1  one-cycle byte strobe, already gated with ioctl_download upstream.
REQ-007 The block SHALL have port ioctl_addr  input  17  byte address of ioctl_data.
REQ-008 The block SHALL have port ioctl_data  input  8  download byte.
REQ-009 The block SHALL have port ram_we  output  1  one-cycle word write strobe to pattern RAM.
REQ-010 The block SHALL have port ram_addr  output  16  word address (byte address >> 1).
REQ-011 The block SHALL have port ram_wdata  output  16  word data, little-endian {odd byte, even byte}.
REQ-012 The block SHALL have port core_reset  output  1  holds the suite datapath in reset.
REQ-013 The block SHALL have port load_done  output  1  last load finished and core released.
REQ-014 The block SHALL have port load_err  output  1  last load had an addressing fault; sticky until next load.
REQ-015 The block SHALL have port load_len  output  17  bytes accepted in the last load.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, FLUSH, RELEASE, DONE.
REQ-017 IDLE/DONE -> LOAD on ioctl_download=1; entry clears load_len, load_err, load_done, the pending byte, and sets expected address to 0.
REQ-018 In LOAD, core_reset SHALL be 1.
REQ-019 An accepted byte SHALL have ioctl_addr equal to the expected address and below MAX_BYTES; each acceptance increments the expected address and load_len by 1.
REQ-020 An accepted even-address byte SHALL be latched as the pending low byte with no RAM write.
REQ-021 An accepted odd-address byte SHALL produce ram_we=1 on the next cycle with ram_addr=ioctl_addr[16:1], ram_wdata={ioctl_data, pending}, then clear pending.
REQ-022 A byte at a non-expected address or at/above MAX_BYTES SHALL be dropped and SHALL set load_err; expected address and load_len are unchanged.
REQ-023 LOAD -> FLUSH on ioctl_download=0; a coincident ioctl_wr byte SHALL be processed before the transition.
REQ-024 FLUSH SHALL last 1 cycle; if a byte is pending, ram_we=1 with ram_wdata={8'h00, pending} at the pending word address.
REQ-025 RELEASE SHALL hold core_reset=1 for exactly RELEASE_CYCLES cycles, then -> DONE.
REQ-026 DONE SHALL drive core_reset=0 and load_done=1.
REQ-027 ioctl_download=1 in FLUSH or RELEASE SHALL take priority: FLUSH completes its write, then -> LOAD with REQ-017 clearing.
REQ-028 ram_we SHALL never be high on two consecutive cycles; ram_addr/ram_wdata SHALL be stable while ram_we=1.
REQ-029 In IDLE, core_reset=0 and ram_we=0.

Reset
REQ-030 On reset=1: state=IDLE, ram_we=0, ram_addr=0, ram_wdata=0, core_reset=0, load_done=0, load_err=0, load_len=0, pending cleared, release counter=0.
REQ-031 Reset during LOAD/FLUSH/RELEASE SHALL abort with no further RAM write; reset dominates all inputs.

Structure
REQ-032 The FSM state enum, RAM word width (16) and word address width (16) SHALL be defined in shared package suite_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the RELEASE counter width SHALL be $clog2(RELEASE_CYCLES+1).

Verification
REQ-034 Download 4 bytes 11,22,33,44 at addr 0..3 -> writes (0,16'h2211) and (1,16'h4433), one cycle after odd strobes; load_len=4; load_err=0.
REQ-035 Download 3 bytes AA,BB,CC then drop download -> FLUSH writes (1,16'h00CC); core_reset high 16 cycles after FLUSH; then load_done=1.
REQ-036 Bytes at addr 0,1,3 -> addr 3 dropped, load_err=1, load_len=2, single write (0,…).
REQ-037 Last byte strobed in same cycle download falls -> byte written, then FLUSH, load_len correct.
REQ-038 Reset asserted in RELEASE after 5 cycles -> next cycle core_reset=0, load_done=0, state IDLE, no ram_we.
REQ-039 Download re-asserted in RELEASE -> LOAD, load_err/load_len cleared, core_reset stays 1 throughout.
